seg_display_ctrl: RTL

//  Parametrised N-digit 7-segment display controller. Loads a binary value and renders it in hex or decimal.

---
 rtl/seg_display_ctrl_pkg.sv | 71 +++++++
 rtl/seg_display_ctrl_bin2bcd_seq.sv | 62 ++++++
 rtl/seg_display_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/seg_display_ctrl_pkg.sv
// Shared radix codes, segment glyphs, FSM state type and sizing helpers for the 7-segment controller.
// Optional feature macro used by the top: LEADING_ZERO_BLANK_EN.
`ifndef RADIX_HEX
`define RADIX_HEX 1'b0
`endif
`ifndef RADIX_DEC
`define RADIX_DEC 1'b1
`endif

package seg_display_ctrl_pkg;

    // Glyphs are active-high {g,f,e,d,c,b,a}; polarity is applied at the output stage.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_SHOW = 2'd2
    } disp_state_e;

    function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = SEG_0;
            4'h1:    g = SEG_1;
            4'h2:    g = SEG_2;
            4'h3:    g = SEG_3;
            4'h4:    g = SEG_4;
            4'h5:    g = SEG_5;
            4'h6:    g = SEG_6;
            4'h7:    g = SEG_7;
            4'h8:    g = SEG_8;
            4'h9:    g = SEG_9;
            4'hA:    g = SEG_A;
            4'hB:    g = SEG_B;
            4'hC:    g = SEG_C;
            4'hD:    g = SEG_D;
            4'hE:    g = SEG_E;
            4'hF:    g = SEG_F;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // ceil(w*log10(2) + 1); w*log10(2) is never an integer for w > 0, so floor + 2 is exact.
    function automatic int bcd_digits(input int w);
        return (w * 30103) / 100000 + 2;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg_display_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock, VALUE_W iterations per start.
// busy deasserts while the final shift is being applied, so bcd is settled from the following edge on.
module seg_display_ctrl_bin2bcd_seq
    import seg_display_ctrl_pkg::*;
#(
    parameter int VALUE_W    = 20,
    parameter int BCD_DIGITS = 8
) (
    input  logic                    src_clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [VALUE_W-1:0]      value,
    output logic                    busy,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    localparam int CNT_W = $clog2(VALUE_W + 1);

    logic [CNT_W-1:0]        cnt_r;
    logic [VALUE_W-1:0]      sh_r;
    logic [4*BCD_DIGITS-1:0] bcd_r;
    logic [4*BCD_DIGITS-1:0] bcd_adj_s;
    logic                    busy_r;

    // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
    always_comb begin
        bcd_adj_s = bcd_r;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (bcd_r[4*d +: 4] >= 4'd5) begin
                bcd_adj_s[4*d +: 4] = bcd_r[4*d +: 4] + 4'd3;
            end else begin
                bcd_adj_s[4*d +: 4] = bcd_r[4*d +: 4];
            end
        end
    end

    // Shift register, BCD accumulator and iteration counter.
    always_ff @(posedge src_clk) begin
        if (rst) begin
            cnt_r  <= '0;
            sh_r   <= '0;
            bcd_r  <= '0;
            busy_r <= 1'b0;
        end else if (start) begin
            cnt_r  <= CNT_W'(VALUE_W);
            sh_r   <= value;
            bcd_r  <= '0;
            busy_r <= 1'b1;
        end else if (cnt_r != '0) begin
            cnt_r  <= cnt_r - CNT_W'(1);
            sh_r   <= {sh_r[VALUE_W-2:0], 1'b0};
            bcd_r  <= {bcd_adj_s[4*BCD_DIGITS-2:0], sh_r[VALUE_W-1]};
            busy_r <= (cnt_r > CNT_W'(2));
        end else begin
            busy_r <= 1'b0;
        end
    end

    assign busy = busy_r;
    assign bcd  = bcd_r;

endmodule

// File: rtl/seg_display_ctrl.sv
// N-digit 7-segment controller: hex or decimal rendering with load/busy/done handshake and overflow flag.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module seg_display_ctrl
    import seg_display_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int VALUE_W     = 20,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic                    src_clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    radix,
    input  logic [VALUE_W-1:0]      value,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [NUM_DIGITS*7-1:0] seg
);

    localparam int BCD_DIGITS = bcd_digits(VALUE_W);
    localparam int WIDE_DIG   = max_int(BCD_DIGITS, NUM_DIGITS);
    localparam int WIDE_W     = 4 * WIDE_DIG;
    localparam logic [6:0] SEG_OFF = (SEG_ACT_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;

    disp_state_e             state_r, state_next_s;
    logic [VALUE_W-1:0]      value_r;
    logic                    radix_r;
    logic                    busy_r, done_r, ovf_r;
    logic [NUM_DIGITS*7-1:0] seg_r;

    logic                    latch_s, conv_start_s, commit_s;
    logic                    conv_busy_s;
    logic [4*BCD_DIGITS-1:0] bcd_s;

    logic [WIDE_W-1:0]       hex_wide_s, dec_wide_s, dig_src_s;
    logic                    ovf_s, dash_s, seen_s;
    logic [3:0]              nib_s;
    logic [6:0]              glyph_s;
    logic [NUM_DIGITS*7-1:0] image_s;

    seg_display_ctrl_bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .src_clk (src_clk),
        .rst     (rst),
        .start   (conv_start_s),
        .value   (value),
        .busy    (conv_busy_s),
        .bcd     (bcd_s)
    );

    // Next-state logic; SHOW is the single cycle whose closing edge publishes the new image.
    always_comb begin
        state_next_s = state_r;
        latch_s      = 1'b0;
        conv_start_s = 1'b0;
        commit_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    latch_s = 1'b1;
                    if (radix == `RADIX_DEC) begin
                        conv_start_s = 1'b1;
                        state_next_s = ST_CONV;
                    end else begin
                        state_next_s = ST_SHOW;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (!conv_busy_s) begin
                    state_next_s = ST_SHOW;
                end else begin
                    state_next_s = ST_CONV;
                end
            end
            ST_SHOW: begin
                commit_s     = 1'b1;
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Digit selection, overflow detection, glyph encode, optional blanking and polarity.
    always_comb begin
        hex_wide_s                    = '0;
        hex_wide_s[VALUE_W-1:0]       = value_r;
        dec_wide_s                    = '0;
        dec_wide_s[4*BCD_DIGITS-1:0]  = bcd_s;
        if (radix_r == `RADIX_DEC) begin
            dig_src_s = dec_wide_s;
        end else begin
            dig_src_s = hex_wide_s;
        end
        ovf_s   = |(dig_src_s >> (4 * NUM_DIGITS));
        dash_s  = ovf_s && (radix_r == `RADIX_DEC);
        seen_s  = 1'b0;
        nib_s   = 4'd0;
        glyph_s = SEG_BLANK;
        image_s = '0;
        // Scan from the top digit so seen_s marks the most significant nonzero digit and below.
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            nib_s = dig_src_s[4*d +: 4];
            if ((nib_s != 4'd0) || (d == 0)) begin
                seen_s = 1'b1;
            end else begin
                seen_s = seen_s;
            end
`ifdef LEADING_ZERO_BLANK_EN
            if (seen_s) begin
                glyph_s = seg_glyph(nib_s);
            end else begin
                glyph_s = SEG_BLANK;
            end
`else
            glyph_s = seg_glyph(nib_s);
`endif
            if (dash_s) begin
                glyph_s = SEG_DASH;
            end else begin
                glyph_s = glyph_s;
            end
            if (SEG_ACT_LOW != 0) begin
                image_s[7*d +: 7] = ~glyph_s;
            end else begin
                image_s[7*d +: 7] = glyph_s;
            end
        end
    end

    // FSM state, request latch and handshake flags.
    always_ff @(posedge src_clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            value_r <= '0;
            radix_r <= `RADIX_HEX;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
            done_r  <= commit_s;
            if (latch_s) begin
                value_r <= value;
                radix_r <= radix;
            end else begin
                value_r <= value_r;
                radix_r <= radix_r;
            end
        end
    end

    // Displayed image and overflow only change on the commit edge.
    always_ff @(posedge src_clk) begin
        if (rst) begin
            seg_r <= {NUM_DIGITS{SEG_OFF}};
            ovf_r <= 1'b0;
        end else if (commit_s) begin
            seg_r <= image_s;
            ovf_r <= ovf_s;
        end else begin
            seg_r <= seg_r;
            ovf_r <= ovf_r;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign overflow = ovf_r;
    assign seg      = seg_r;

endmodule
